// File: rtl/sprite_dma_ctl_if.sv
// Signal bundle between the raster/bus-cycle logic and the sprite DMA controller.
// The controller takes the slave side; the driving environment takes the master side.
interface sprite_dma_ctl_if;
  logic        phi_phase_start_1;
  logic        clk_phi;
  logic [6:0]  cycle_num;
  logic [8:0]  raster_line;
  logic [7:0]  sprite_en;
  logic [7:0]  sprite_ye;
  logic        ye_wr;
  logic [63:0] sprite_y;
  logic        s_access;
  logic [2:0]  s_idx;
  logic [7:0]  sprite_dma;
  logic [7:0]  sprite_display;
  logic [47:0] sprite_mc;
  logic [7:0]  expand_ff;

  modport master (
    output phi_phase_start_1, clk_phi, cycle_num, raster_line,
    output sprite_en, sprite_ye, ye_wr, sprite_y, s_access, s_idx,
    input  sprite_dma, sprite_display, sprite_mc, expand_ff
  );

  modport slave (
    input  phi_phase_start_1, clk_phi, cycle_num, raster_line,
    input  sprite_en, sprite_ye, ye_wr, sprite_y, s_access, s_idx,
    output sprite_dma, sprite_display, sprite_mc, expand_ff
  );
endinterface

// File: rtl/sprite_dma_ctl.sv
// VIC-II style sprite DMA controller: per-sprite DMA/display flags, MC/MCBASE
// data counters and Y-expansion flip-flops, advanced at fixed bus cycles.
module sprite_dma_ctl #(
  parameter int unsigned CYC_DMA_CHK1 = 54,
  parameter int unsigned CYC_DMA_CHK2 = 55,
  parameter int unsigned CYC_MC_LOAD  = 57,
  parameter int unsigned CYC_MCB_ADD2 = 14,
  parameter int unsigned CYC_MCB_ADD1 = 15
) (
  input  logic             clk_dot4x,
  input  logic             rst_n,
  sprite_dma_ctl_if.slave  bus
);

  localparam logic [6:0] CHK1_C = 7'(CYC_DMA_CHK1);
  localparam logic [6:0] CHK2_C = 7'(CYC_DMA_CHK2);
  localparam logic [6:0] LOAD_C = 7'(CYC_MC_LOAD);
  localparam logic [6:0] ADD2_C = 7'(CYC_MCB_ADD2);
  localparam logic [6:0] ADD1_C = 7'(CYC_MCB_ADD1);

  logic [7:0] dma_q, dma_d;
  logic [7:0] disp_q, disp_d;
  logic [7:0] exp_q, exp_d;
  logic [5:0] mc_q  [8];
  logic [5:0] mc_d  [8];
  logic [5:0] mcb_q [8];
  logic [5:0] mcb_d [8];
  logic [6:0] last_cyc_q;
  logic       last_vld_q;

  logic [7:0] ymatch;
  logic       fire;

  // One evaluation per bus cycle even if the phase strobe repeats within it.
  assign fire = bus.phi_phase_start_1 && !bus.clk_phi &&
                !(last_vld_q && (last_cyc_q == bus.cycle_num));

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      ymatch[n] = bus.sprite_en[n] && (bus.sprite_y[8*n +: 8] == bus.raster_line[7:0]);
    end
  end

  // NOTE: combinational next-state uses blocking '=' so later lines can refine
  // earlier ones (load beats s-access, ye_wr beats toggle); registers use '<='.
  always_comb begin
    dma_d  = dma_q;
    disp_d = disp_q;
    exp_d  = exp_q;
    mc_d   = mc_q;
    mcb_d  = mcb_q;

    if (bus.s_access && dma_q[bus.s_idx]) begin
      mc_d[bus.s_idx] = mc_q[bus.s_idx] + 6'd1;
    end

    if (fire) begin
      if (bus.cycle_num == CHK1_C) begin
        exp_d = exp_q ^ bus.sprite_ye;
      end
      for (int n = 0; n < 8; n++) begin
        if ((bus.cycle_num == CHK1_C || bus.cycle_num == CHK2_C) && ymatch[n] && !dma_q[n]) begin
          dma_d[n] = 1'b1;
          mcb_d[n] = 6'd0;
          if (bus.sprite_ye[n]) exp_d[n] = 1'b0;
        end
        if (bus.cycle_num == LOAD_C) begin
          mc_d[n] = mcb_q[n];
          if (dma_q[n] && ymatch[n]) disp_d[n] = 1'b1;
        end
        if (bus.cycle_num == ADD2_C && exp_q[n]) begin
          mcb_d[n] = mcb_q[n] + 6'd2;
        end
        if (bus.cycle_num == ADD1_C) begin
          if (exp_q[n]) mcb_d[n] = mcb_q[n] + 6'd1;
          if (mcb_d[n] == 6'd63) begin
            dma_d[n]  = 1'b0;
            disp_d[n] = 1'b0;
          end
        end
      end
    end

    if (bus.ye_wr) begin
      exp_d = exp_d | ~bus.sprite_ye;
    end
  end

  // NOTE: the counter arrays are small register files, not RAM, so they are
  // cleared by reset like any other state.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      dma_q      <= 8'h00;
      disp_q     <= 8'h00;
      exp_q      <= 8'hFF;
      last_cyc_q <= 7'd0;
      last_vld_q <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        mc_q[n]  <= 6'd0;
        mcb_q[n] <= 6'd0;
      end
    end else begin
      dma_q  <= dma_d;
      disp_q <= disp_d;
      exp_q  <= exp_d;
      mc_q   <= mc_d;
      mcb_q  <= mcb_d;
      if (fire) begin
        last_cyc_q <= bus.cycle_num;
        last_vld_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      bus.sprite_mc[6*n +: 6] = mc_q[n];
    end
  end

  assign bus.sprite_dma     = dma_q;
  assign bus.sprite_display = disp_q;
  assign bus.expand_ff      = exp_q;

endmodule

// File: tb/tb_sprite_dma_ctl.sv
// Scoreboard bench for sprite_dma_ctl: stimulus queues expected output values,
// a monitor process pops and compares them away from the active clock edge.
module tb_sprite_dma_ctl;

  localparam int SEL_DMA  = 0;
  localparam int SEL_DISP = 1;
  localparam int SEL_EXP  = 2;
  localparam int SEL_MC   = 3;
  localparam logic [47:0] ALL = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    string       name;
    int          sel;
    logic [47:0] mask;
    logic [47:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  event chk_now;
  logic [6:0] last_cyc;
  logic       last_ok;

  sprite_dma_ctl_if bus ();

  sprite_dma_ctl dut (
    .clk_dot4x (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pick(input int sel);
    case (sel)
      SEL_DMA:  return {40'd0, bus.sprite_dma};
      SEL_DISP: return {40'd0, bus.sprite_display};
      SEL_EXP:  return {40'd0, bus.expand_ff};
      default:  return bus.sprite_mc;
    endcase
  endfunction

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, pick(e.sel) & e.mask, e.val & e.mask);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input string name, input int sel, input logic [47:0] mask,
                          input logic [47:0] val);
    sb_q.push_back('{name, sel, mask, val});
  endtask

  // One clock tick; called and returning at #1 after a rising edge.
  task automatic tick(input logic do_et, input logic [6:0] cyc, input logic sacc,
                      input logic [2:0] idx, input logic yw);
    if (do_et && last_ok && cyc == last_cyc) begin
      // Same cycle twice in a row would be suppressed; step through an idle cycle.
      bus.cycle_num = 7'd1;
      bus.phi_phase_start_1 = 1'b1;
      @(posedge clk); #1;
      bus.phi_phase_start_1 = 1'b0;
    end
    bus.cycle_num         = cyc;
    bus.phi_phase_start_1 = do_et;
    bus.s_access          = sacc;
    bus.s_idx             = idx;
    bus.ye_wr             = yw;
    @(posedge clk); #1;
    bus.phi_phase_start_1 = 1'b0;
    bus.s_access          = 1'b0;
    bus.ye_wr             = 1'b0;
    if (do_et) begin
      last_cyc = cyc;
      last_ok  = 1'b1;
    end
  endtask

  task automatic et(input logic [6:0] cyc);
    tick(1'b1, cyc, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic sa(input logic [2:0] idx);
    tick(1'b0, bus.cycle_num, 1'b1, idx, 1'b0);
  endtask

  task automatic set_y(input int n, input logic [7:0] y);
    bus.sprite_y[8*n +: 8] = y;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_ok  = 1'b0;
    last_cyc = 7'd0;
    rst_n    = 1'b0;
    bus.phi_phase_start_1 = 1'b0;
    bus.clk_phi     = 1'b0;
    bus.cycle_num   = 7'd0;
    bus.raster_line = 9'd0;
    bus.sprite_en   = 8'h00;
    bus.sprite_ye   = 8'h00;
    bus.ye_wr       = 1'b0;
    bus.sprite_y    = 64'd0;
    bus.s_access    = 1'b0;
    bus.s_idx       = 3'd0;

    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_v("rst_dma",  SEL_DMA,  ALL, 48'h00);
    expect_v("rst_disp", SEL_DISP, ALL, 48'h00);
    expect_v("rst_exp",  SEL_EXP,  ALL, 48'hFF);
    expect_v("rst_mc",   SEL_MC,   ALL, 48'h0);

    // Sprite 0 DMA start and display enable.
    bus.sprite_en   = 8'h01;
    set_y(0, 8'h32);
    bus.raster_line = 9'h032;
    et(7'd54);
    expect_v("start_dma", SEL_DMA, ALL, 48'h01);
    expect_v("start_exp", SEL_EXP, ALL, 48'hFF);
    et(7'd55);
    et(7'd57);
    expect_v("load_disp", SEL_DISP, ALL, 48'h01);
    expect_v("load_mc",   SEL_MC,   ALL, 48'h0);

    // Unexpanded sprite: three fetches and +3 MCBASE per line, 21 lines to 63.
    bus.raster_line = 9'h100;
    for (int k = 1; k <= 21; k++) begin
      repeat (3) sa(3'd0);
      expect_v($sformatf("mc0_fetch_%0d", k), SEL_MC, 48'h3F, 48'(3 * k));
      et(7'd14);
      et(7'd15);
      if (k == 20) expect_v("dma_before_end", SEL_DMA, ALL, 48'h01);
      if (k < 21) begin
        et(7'd54);
        et(7'd55);
        et(7'd57);
        expect_v($sformatf("mcbase0_line_%0d", k), SEL_MC, 48'h3F, 48'(3 * k));
      end
    end
    expect_v("end_dma",  SEL_DMA,  ALL, 48'h00);
    expect_v("end_disp", SEL_DISP, ALL, 48'h00);

    // Y-expanded sprite 0: MCBASE advances on every second line, 42 lines to 63.
    bus.sprite_ye   = 8'h01;
    bus.raster_line = 9'h032;
    et(7'd54);
    expect_v("ye_start_exp", SEL_EXP, ALL, 48'hFE);
    expect_v("ye_start_dma", SEL_DMA, ALL, 48'h01);
    bus.raster_line = 9'h100;
    et(7'd55);
    et(7'd57);
    for (int j = 1; j <= 42; j++) begin
      et(7'd14);
      et(7'd15);
      if (j == 41) expect_v("ye_dma_41", SEL_DMA, ALL, 48'h01);
      if (j == 42) expect_v("ye_dma_42", SEL_DMA, ALL, 48'h00);
      et(7'd54);
      expect_v($sformatf("ye_exp_%0d", j), SEL_EXP, ALL, (j % 2 == 1) ? 48'hFF : 48'hFE);
      et(7'd55);
      et(7'd57);
      expect_v($sformatf("ye_mc0_%0d", j), SEL_MC, 48'h3F, 48'(3 * (j / 2)));
    end

    // ye_wr sets only the flip-flops whose expand bit is clear.
    tick(1'b0, 7'd56, 1'b0, 3'd0, 1'b1);
    expect_v("yewr_keep", SEL_EXP, ALL, 48'hFE);
    bus.sprite_en   = 8'h08;
    set_y(3, 8'h40);
    bus.raster_line = 9'h040;
    bus.sprite_ye   = 8'h00;
    tick(1'b1, 7'd54, 1'b0, 3'd0, 1'b1);
    expect_v("yewr_chk1_exp", SEL_EXP, ALL, 48'hFF);
    expect_v("yewr_chk1_dma", SEL_DMA, ALL, 48'h08);

    // s-access behaviour: ignored without DMA, wraps at 63, loses to MC load.
    sa(3'd2);
    expect_v("sacc_no_dma", SEL_MC, 48'h3F000, 48'h3D000);
    bus.sprite_en   = 8'h02;
    set_y(1, 8'h50);
    bus.raster_line = 9'h050;
    et(7'd55);
    expect_v("chk2_dma", SEL_DMA, ALL, 48'h0A);
    repeat (2) sa(3'd1);
    expect_v("mc1_at_63", SEL_MC, 48'hFC0, 48'hFC0);
    sa(3'd1);
    expect_v("mc1_wrap", SEL_MC, 48'hFC0, 48'h000);
    sa(3'd3);
    expect_v("mc3_pre", SEL_MC, 48'hFC0000, 48'hF80000);
    tick(1'b1, 7'd57, 1'b1, 3'd3, 1'b0);
    expect_v("load_beats_sacc", SEL_MC, 48'hFC0FC0, 48'h0);
    expect_v("load_disp1", SEL_DISP, ALL, 48'h02);

    // All sprites on, then asynchronous reset mid-line.
    bus.sprite_en = 8'hFF;
    for (int n = 0; n < 8; n++) set_y(n, 8'h60);
    bus.raster_line = 9'h060;
    et(7'd54);
    expect_v("all_dma", SEL_DMA, ALL, 48'hFF);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    expect_v("async_rst_dma",  SEL_DMA,  ALL, 48'h00);
    expect_v("async_rst_disp", SEL_DISP, ALL, 48'h00);
    expect_v("async_rst_exp",  SEL_EXP,  ALL, 48'hFF);
    expect_v("async_rst_mc",   SEL_MC,   ALL, 48'h0);
    -> chk_now;
    #10 rst_n = 1'b1;
    last_ok = 1'b0;
    @(posedge clk); #1;

    // Phase strobe with clk_phi high is not an evaluation tick.
    bus.clk_phi = 1'b1;
    et(7'd54);
    bus.clk_phi = 1'b0;
    expect_v("no_et_dma", SEL_DMA, ALL, 48'h00);
    last_ok = 1'b0;
    et(7'd54);
    expect_v("post_rst_dma", SEL_DMA, ALL, 48'hFF);

    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
